// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types, 640x480@60 defaults and a total-count helper.
package vga_pkg;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP = 33;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_H_DEFAULT = '{VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP};
  localparam vga_timing_t VGA_V_DEFAULT = '{VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP};
  function automatic int unsigned vga_total(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel enable in, raster timing out; master is the generator.
// frame_count exists only when VGA_TIMING_FRAMECNT_EN is defined.
interface vga_timing_gen_if #(parameter int CW = 10);
  logic pix_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic hsync;
  logic vsync;
  logic active;
  logic line_start;
  logic frame_start;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_count;
  modport master (input pix_en, output x, y, hsync, vsync, active, line_start, frame_start, frame_count);
  modport slave (output pix_en, input x, y, hsync, vsync, active, line_start, frame_start, frame_count);
`else
  modport master (input pix_en, output x, y, hsync, vsync, active, line_start, frame_start);
  modport slave (output pix_en, input x, y, hsync, vsync, active, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; sync and the active look-ahead are derived
// from the next count so registered outputs line up with the registered count.
module vga_axis_counter import vga_pkg::*; #(
  parameter vga_timing_t T = VGA_H_DEFAULT,
  parameter bit POL = 1'b0,
  parameter int CW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic [CW-1:0] count,
  output logic sync,
  output logic act_nx,
  output logic wrap
);
  localparam int unsigned TOT = vga_total(T);
  localparam logic [CW-1:0] LAST = CW'(TOT - 1);
  localparam logic [CW-1:0] SS = CW'(T.active + T.fp);
  localparam logic [CW-1:0] SE = CW'(T.active + T.fp + T.sync);
  localparam logic [CW-1:0] AE = CW'(T.active);
  if (T.active < 1 || T.fp < 1 || T.sync < 1 || T.bp < 1 || TOT > 2**CW) begin : g_bad_timing
    $fatal(1, "vga_axis_counter: timing parameter below 1 or total exceeds 2**CW");
  end
  logic [CW-1:0] count_q, count_d;
  logic sync_q, sync_d;
  always_comb begin
    wrap = adv && count_q == LAST;
    count_d = !adv ? count_q : wrap ? '0 : count_q + CW'(1);
    sync_d = (count_d >= SS && count_d < SE) ? POL : ~POL;
    act_nx = count_d < AE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      sync_q <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q <= sync_d;
    end
  assign count = count_q;
  assign sync = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with line/frame strobes.
// Define VGA_TIMING_FRAMECNT_EN to add a 16-bit frame counter.
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP = VGA_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW = 10
) (
  input logic Counterclock,
  input logic reset,
  vga_timing_gen_if.master vif
);
  localparam vga_timing_t HT = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
  localparam vga_timing_t VT = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
  logic h_wrap, v_wrap, h_act, v_act;
  logic active_q, active_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  vga_axis_counter #(.T(HT), .POL(HS_POL), .CW(CW)) u_h (
    .clk(Counterclock), .rst(reset), .adv(vif.pix_en), .count(vif.x),
    .sync(vif.hsync), .act_nx(h_act), .wrap(h_wrap));
  // the vertical axis advances only on the horizontal wrap, so vsync moves with it
  vga_axis_counter #(.T(VT), .POL(VS_POL), .CW(CW)) u_v (
    .clk(Counterclock), .rst(reset), .adv(h_wrap), .count(vif.y),
    .sync(vif.vsync), .act_nx(v_act), .wrap(v_wrap));
  always_comb begin
    active_d = h_act && v_act;
    line_start_d = h_wrap;
    frame_start_d = v_wrap;
  end
  always_ff @(posedge Counterclock or posedge reset)
    if (reset) begin
      active_q <= 1'b1;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q <= active_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  assign vif.active = active_q;
  assign vif.line_start = line_start_q;
  assign vif.frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  always_comb frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  always_ff @(posedge Counterclock or posedge reset)
    if (reset) frame_count_q <= '0;
    else frame_count_q <= frame_count_d;
  assign vif.frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three timing generators (full 640x480,
// 640-wide with a 10-line frame, and a tiny positive-polarity raster).
module tb_vga_timing_gen;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tcfg_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  int vec = 0;
  int errs = 0;
  tcfg_t cfg [3];
  int ht [3], vt [3], mx [3], my [3];
  bit mls [3], mfs [3];
  logic [24:0] act [3];
  vga_timing_gen_if #(.CW(10)) ifd ();
  vga_timing_gen_if #(.CW(10)) ifm ();
  vga_timing_gen_if #(.CW(10)) ift ();
  assign ifd.pix_en = en;
  assign ifm.pix_en = en;
  assign ift.pix_en = en;
  vga_timing_gen u_d (.Counterclock(clk), .reset(rst), .vif(ifd));
  vga_timing_gen #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_m (
    .Counterclock(clk), .reset(rst), .vif(ifm));
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) u_t (
    .Counterclock(clk), .reset(rst), .vif(ift));
  assign act[0] = {ifd.x, ifd.y, ifd.active, ifd.hsync, ifd.vsync, ifd.line_start, ifd.frame_start};
  assign act[1] = {ifm.x, ifm.y, ifm.active, ifm.hsync, ifm.vsync, ifm.line_start, ifm.frame_start};
  assign act[2] = {ift.x, ift.y, ift.active, ift.hsync, ift.vsync, ift.line_start, ift.frame_start};
  always #5 clk = ~clk;

  function automatic logic [24:0] expv(tcfg_t c, int x, int y, bit ls, bit fs);
    bit hin = x >= c.ha + c.hf && x < c.ha + c.hf + c.hs;
    bit vin = y >= c.va + c.vf && y < c.va + c.vf + c.vs;
    return {10'(x), 10'(y), x < c.ha && y < c.va, hin ? c.hp : !c.hp, vin ? c.vp : !c.vp, ls, fs};
  endfunction

  task automatic tick(bit e);
    en = e;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mx[i] = 0; my[i] = 0; mls[i] = 0; mfs[i] = 0;
      end else if (e) begin
        bit wx = mx[i] == ht[i] - 1;
        bit wy = wx && my[i] == vt[i] - 1;
        mls[i] = wx;
        mfs[i] = wy;
        mx[i] = wx ? 0 : mx[i] + 1;
        if (wx) my[i] = wy ? 0 : my[i] + 1;
      end else begin
        mls[i] = 0; mfs[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0);
    tick(0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(0);
    tick(0);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (act[i] !== expv(cfg[i], 0, 0, 0, 0)) begin
        errs++; $display("FAIL reset_val[%0d] got %h exp %h", i, act[i], expv(cfg[i], 0, 0, 0, 0));
      end
    end
    vec++;
    if ({ifd.active, ifd.hsync, ifd.vsync} !== 3'b111) begin
      errs++; $display("FAIL reset_levels got %b exp 111", {ifd.active, ifd.hsync, ifd.vsync});
    end
    rst = 1'b0;
    tick(0);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (act[i] !== expv(cfg[i], 0, 0, 0, 0)) begin
        errs++; $display("FAIL release_idle[%0d] got %h exp %h", i, act[i], expv(cfg[i], 0, 0, 0, 0));
      end
    end
    tick(1);
    vec++;
    if ({ifd.x, ifd.y, ifd.line_start, ifd.frame_start} !== {10'd1, 10'd0, 2'b00}) begin
      errs++; $display("FAIL first_edge got x=%0d y=%0d ls=%b fs=%b exp x=1 y=0 ls=0 fs=0",
        ifd.x, ifd.y, ifd.line_start, ifd.frame_start);
    end
  endtask

  task automatic test_line();
    for (int n = 0; n < 2400; n++) begin
      tick(1);
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (act[i] !== expv(cfg[i], mx[i], my[i], mls[i], mfs[i])) begin
          errs++; $display("FAIL line[%0d] t=%0d got %h exp %h", i, n, act[i], expv(cfg[i], mx[i], my[i], mls[i], mfs[i]));
        end
      end
      vec++;
      if (ifd.hsync !== !(mx[0] >= 656 && mx[0] <= 751)) begin
        errs++; $display("FAIL hsync_window x=%0d got %b exp %b", mx[0], ifd.hsync, !(mx[0] >= 656 && mx[0] <= 751));
      end
    end
  endtask

  task automatic test_frame();
    int seen = 0, cyc = 0, ac = 0, n = 0;
    while (seen < 2 && n < 20000) begin
      tick(1);
      n++;
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (act[i] !== expv(cfg[i], mx[i], my[i], mls[i], mfs[i])) begin
          errs++; $display("FAIL frame[%0d] got %h exp %h", i, act[i], expv(cfg[i], mx[i], my[i], mls[i], mfs[i]));
        end
      end
      if (ifm.frame_start) begin
        if (seen > 0) begin
          vec++;
          if (cyc !== 8000 || ac !== 3840) begin
            errs++; $display("FAIL frame_len got cycles=%0d active=%0d exp 8000/3840", cyc, ac);
          end
        end
        seen++; cyc = 0; ac = 0;
      end
      cyc++;
      ac += int'(ifm.active);
    end
    if (seen < 2) begin
      vec++; errs++; $display("FAIL frame_timeout got %0d frame starts exp 2", seen);
    end
  endtask

  task automatic test_stall();
    int seen = 0, cnt = 0, n = 0;
    while (seen < 2 && n < 30000) begin
      bit e = $urandom_range(3, 0) != 0;
      tick(e);
      n++;
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (act[i] !== expv(cfg[i], mx[i], my[i], mls[i], mfs[i])) begin
          errs++; $display("FAIL stall[%0d] en=%b got %h exp %h", i, e, act[i], expv(cfg[i], mx[i], my[i], mls[i], mfs[i]));
        end
      end
      cnt += int'(e);
      if (ifm.frame_start) begin
        if (seen > 0) begin
          vec++;
          if (cnt !== 8000) begin
            errs++; $display("FAIL stall_frame_len got %0d enabled edges exp 8000", cnt);
          end
        end
        seen++; cnt = 0;
      end
    end
    if (seen < 2) begin
      vec++; errs++; $display("FAIL stall_timeout got %0d frame starts exp 2", seen);
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    while (!(mx[1] == 700 && my[1] == 5) && n < 10000) begin
      tick(1);
      n++;
    end
    vec++;
    if (ifm.x !== 10'd700 || ifm.y !== 10'd5) begin
      errs++; $display("FAIL midreset_reach got x=%0d y=%0d exp x=700 y=5", ifm.x, ifm.y);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (act[i] !== expv(cfg[i], 0, 0, 0, 0)) begin
        errs++; $display("FAIL async_reset[%0d] got %h exp %h", i, act[i], expv(cfg[i], 0, 0, 0, 0));
      end
    end
    tick(0);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (act[i] !== expv(cfg[i], mx[i], my[i], mls[i], mfs[i])) begin
          errs++; $display("FAIL restart[%0d] k=%0d got %h exp %h", i, k, act[i], expv(cfg[i], mx[i], my[i], mls[i], mfs[i]));
        end
      end
    end
  endtask

  task automatic test_tiny();
    do_reset();
    for (int n = 0; n < 100; n++) begin
      tick(1);
      vec++;
      if (act[2] !== expv(cfg[2], mx[2], my[2], mls[2], mfs[2])) begin
        errs++; $display("FAIL tiny t=%0d got %h exp %h", n, act[2], expv(cfg[2], mx[2], my[2], mls[2], mfs[2]));
      end
      vec++;
      if (ift.hsync !== (mx[2] == 5 || mx[2] == 6) || ift.vsync !== (my[2] == 4)) begin
        errs++; $display("FAIL tiny_sync x=%0d y=%0d got hs=%b vs=%b", mx[2], my[2], ift.hsync, ift.vsync);
      end
    end
  endtask

`ifdef VGA_TIMING_FRAMECNT_EN
  task automatic test_frame_count();
    int efc = 0, n = 0;
    do_reset();
    vec++;
    if (ift.frame_count !== 16'd0) begin
      errs++; $display("FAIL fc_reset got %0d exp 0", ift.frame_count);
    end
    while (efc < 3 && n < 500) begin
      tick(1);
      n++;
      if (mfs[2]) efc++;
      vec++;
      if (ift.frame_count !== 16'(efc) || ift.frame_start !== mfs[2]) begin
        errs++; $display("FAIL fc_step got %0d fs=%b exp %0d fs=%b", ift.frame_count, ift.frame_start, efc, mfs[2]);
      end
    end
    vec++;
    if (ift.frame_count !== 16'd3) begin
      errs++; $display("FAIL fc_three got %0d exp 3", ift.frame_count);
    end
    force u_t.frame_count_q = 16'hffff;
    #1;
    release u_t.frame_count_q;
    n = 0;
    while (!mfs[2] && n < 100) begin
      tick(1);
      n++;
    end
    vec++;
    if (ift.frame_count !== 16'd0 || !ift.frame_start) begin
      errs++; $display("FAIL fc_wrap got %0d fs=%b exp 0 fs=1", ift.frame_count, ift.frame_start);
    end
  endtask
`endif

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{640, 16, 96, 48, 6, 1, 2, 1, 1'b0, 1'b0};
    cfg[2] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      ht[i] = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
      vt[i] = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
    end
    test_reset();
    test_line();
    test_frame();
    test_stall();
    test_midreset();
    test_tiny();
`ifdef VGA_TIMING_FRAMECNT_EN
    test_frame_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
